dram_imc_mac_engine: RTL and testbench
======================================

Name: dram_imc_mac_engine

Overview:
- Next-generation multi-bank DRAM in-memory-compute engine; supersedes the fixed 8-element sum with a variable-length signed dot-product / reduction.
- Performs READ, WRITE (overwrite or saturating accumulate), SUM and MAC on any subset of banks in parallel.
- Combines per-bank partials into one saturated result.
- Sits between the hybrid-IMC command scheduler (valid/ready) and the result collector (valid/ready back-pressure).

Parameters:
- DATA_WIDTH, 8, signed element width.
- ACC_WIDTH, 24, signed accumulator/result width (must be ≥ 2*DATA_WIDTH).
- NUM_BANKS, 4, bank count.
- BANK_DEPTH, 1024, words per bank (power of 2); BANK_AW = $clog2(BANK_DEPTH).
- MAX_LEN, 64, max elements per SUM/MAC; LEN_W = $clog2(MAX_LEN)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  3  000 READ, 001 WRITE, 010 SUM, 011 MAC, others illegal.
- cmd_bank_mask  in  NUM_BANKS  banks participating.
- cmd_addr_a  in  BANK_AW  operand-A / target address.
- cmd_addr_b  in  BANK_AW  operand-B base (MAC only).
- cmd_len  in  LEN_W  element count (SUM/MAC).
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_accumulate  in  1  WRITE adds to stored value instead of overwriting.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  collector accepts result.
- rsp_data  out  ACC_WIDTH  result.
- rsp_sat  out  1  saturation occurred in this command.
- rsp_err  out  1  illegal op, empty mask, or len > MAX_LEN.
- stat_elem_ops  out  16  element-operations executed, saturating.
- stat_energy  out  16  energy units, saturating.

Behaviour:
- Interface: one clock (clk); synchronous, active-low reset (rst_n), sampled on the rising edge of clk.
- Reset values:
  - cmd_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_sat=0, rsp_err=0.
  - stat_elem_ops=0, stat_energy=0.
  - All bank accumulators, element counter and sat flags cleared; FSM to IDLE.
  - Memory contents are not cleared.
- Reset mid-operation aborts the command; no response is produced. A memory write already committed remains.
- FSM states: IDLE → RUN → COMBINE → RESP → IDLE.
- IDLE:
  - cmd_ready=1. Accept on cmd_valid && cmd_ready (cycle T). Latch all cmd fields; clear accumulators and the sat flag.
  - Error commands (illegal op, mask==0, or len>MAX_LEN for SUM/MAC) go directly to RESP with rsp_err=1, rsp_data=0, no memory access. rsp_valid is high at T+1.
  - SUM/MAC with len==0 go to COMBINE and return 0.
- RUN:
  - cmd_ready=0.
  - Effective length N: 1 for READ/WRITE, cmd_len for SUM/MAC.
  - Element i is processed in cycle T+1+i, in every masked bank in parallel.
  - Addresses are (addr_a+i) and (addr_b+i) mod BANK_DEPTH, so they wrap within the bank.
- Per-op, per-bank action:
  - READ: acc = sign-extend(mem[a]).
  - WRITE overwrite: mem[a] <= wdata.
  - WRITE accumulate: mem[a] <= sat_DATA(mem[a]+wdata), to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Set sat if clamped.
  - SUM: acc <= sat_ACC(acc + mem[a+i]).
  - MAC: acc <= sat_ACC(acc + mem[a+i]*mem[b+i]), full 2*DATA_WIDTH signed product.
  - Any clamp sets the sticky sat flag.
- COMBINE (one cycle):
  - READ: result = acc of the lowest-index masked bank.
  - WRITE: result = 0.
  - SUM/MAC: result = sat_ACC(Σ acc over masked banks). A clamp here also sets sat.
  - Register rsp_data and rsp_sat.
- RESP:
  - rsp_valid=1 from cycle T+2+N (T+2 for len==0) until rsp_valid && rsp_ready. rsp_data, rsp_sat and rsp_err are held stable while stalled.
  - On the handshake, go to IDLE with rsp_valid low the next cycle. The next command can be accepted in the cycle after the handshake.
- Stats update on each executed element per active bank:
  - stat_elem_ops +1.
  - stat_energy +2 for READ/WRITE, +3 for SUM, +5 for MAC.
  - Both counters saturate at 16'hFFFF. Error commands add nothing.
- Simultaneous cmd_valid while busy: ignored (cmd_ready=0); the command must be held by the source.

Test Plan:
- Write then read: WRITE bank0 addr 5 = 8'h7E (mask 0001, overwrite), then READ same → rsp_data=24'h00007E at T+3; READ of 8'h80 → 24'hFFFF80.
- Accumulate saturation: mem=100, WRITE accumulate 50 → mem=127, rsp_sat=1; mem=-100, add -50 → -128, rsp_sat=1.
- Multi-bank MAC: banks 0–3 hold A[i]=i+1, B[i]=2 at addrs 0..7/64..71; MAC mask 1111, len 8, a=0, b=64 → per bank 72, rsp_data=288. rsp_valid at T+10; stat_elem_ops=32, stat_energy=160.
- Wrap and back-pressure: SUM len 4 at addr 1022 on bank2 (values 1,2,3,4 at 1022,1023,0,1) → 10. Hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_data stable, cmd_ready=0 throughout.
- Errors: op=3'b111, then mask=0, then len=MAX_LEN+1 → each gives rsp_err=1, rsp_data=0 at T+1, stats unchanged.
- Reset mid-MAC: assert rst_n=0 during RUN cycle 3 of a len-16 MAC → next cycle rsp_valid=0, cmd_ready=1, stats=0. A new READ succeeds normally.

Source files
------------

// File: rtl/dram_imc_mac_engine_if.sv
// Command channel from the hybrid-IMC scheduler and response channel to the
// result collector, both using valid/ready handshakes.
interface dram_imc_mac_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_AW    = 10,
  parameter int LEN_W      = 7
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [NUM_BANKS-1:0]  cmd_bank_mask;
  logic [BANK_AW-1:0]    cmd_addr_a;
  logic [BANK_AW-1:0]    cmd_addr_b;
  logic [LEN_W-1:0]      cmd_len;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  cmd_accumulate;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ACC_WIDTH-1:0]  rsp_data;
  logic                  rsp_sat;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_bank_mask, cmd_addr_a, cmd_addr_b, cmd_len,
           cmd_wdata, cmd_accumulate, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_sat, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bank_mask, cmd_addr_a, cmd_addr_b, cmd_len,
           cmd_wdata, cmd_accumulate, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_sat, rsp_err
  );
endinterface

// File: rtl/dram_imc_mac_engine.sv
// Multi-bank DRAM in-memory-compute engine: READ/WRITE/SUM/MAC over any bank subset,
// one element per cycle per bank, partials combined into one saturated result.
module dram_imc_mac_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 1024,
  parameter int MAX_LEN    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  dram_imc_mac_engine_if.slave bus,
  output logic [15:0] stat_elem_ops,
  output logic [15:0] stat_energy
);
  localparam int BANK_AW = $clog2(BANK_DEPTH);
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int ACC1_W  = ACC_WIDTH + 1;
  localparam int DAT1_W  = DATA_WIDTH + 1;
  localparam int PROD_W  = 2 * DATA_WIDTH;
  localparam int TOT_W   = ACC_WIDTH + $clog2(NUM_BANKS) + 1;

  localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] DAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMBINE, S_RESP} state_t;
  typedef enum logic [2:0] {OP_READ = 3'd0, OP_WRITE = 3'd1, OP_SUM = 3'd2, OP_MAC = 3'd3} op_t;

  state_t                        state_q, state_d;
  logic [2:0]                    op_q, op_d;
  logic [NUM_BANKS-1:0]          mask_q, mask_d;
  logic [BANK_AW-1:0]            addr_a_q, addr_a_d;
  logic [BANK_AW-1:0]            addr_b_q, addr_b_d;
  logic [LEN_W-1:0]              len_q, len_d;
  logic [LEN_W-1:0]              idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                          accum_q, accum_d;
  logic signed [ACC_WIDTH-1:0]   acc_q [NUM_BANKS];
  logic signed [ACC_WIDTH-1:0]   acc_d [NUM_BANKS];
  logic                          sat_q, sat_d;
  logic [ACC_WIDTH-1:0]          rsp_data_q, rsp_data_d;
  logic                          rsp_sat_q, rsp_sat_d;
  logic                          rsp_err_q, rsp_err_d;
  logic [15:0]                   elem_q, elem_d;
  logic [15:0]                   energy_q, energy_d;

  // Bank storage is deliberately never reset; contents survive rst_n.
  logic signed [DATA_WIDTH-1:0]  bank_mem [NUM_BANKS][BANK_DEPTH];

  logic [BANK_AW-1:0]            addr_a_cur, addr_b_cur;
  logic signed [DATA_WIDTH-1:0]  rd_a [NUM_BANKS];
  logic signed [DATA_WIDTH-1:0]  rd_b [NUM_BANKS];
  logic signed [PROD_W-1:0]      prod [NUM_BANKS];
  logic signed [ACC1_W-1:0]      acc_in [NUM_BANKS];
  logic signed [ACC1_W-1:0]      acc_sum [NUM_BANKS];
  logic                          acc_ovf [NUM_BANKS];
  logic signed [ACC_WIDTH-1:0]   acc_sat [NUM_BANKS];
  logic signed [DAT1_W-1:0]      wr_sum [NUM_BANKS];
  logic                          wr_ovf [NUM_BANKS];
  logic signed [DATA_WIDTH-1:0]  wr_sat [NUM_BANKS];
  logic [NUM_BANKS-1:0]          wr_en;
  logic signed [DATA_WIDTH-1:0]  wr_data [NUM_BANKS];

  logic signed [TOT_W-1:0]       total;
  logic signed [ACC_WIDTH-1:0]   read_data;
  logic                          comb_ovf;
  logic signed [ACC_WIDTH-1:0]   comb_data;
  int                            active_cnt;
  int                            weight;
  int                            elem_sum;
  int                            energy_sum;
  logic                          is_vec;

  assign addr_a_cur = addr_a_q + BANK_AW'(idx_q);
  assign addr_b_cur = addr_b_q + BANK_AW'(idx_q);

  // Per-bank element datapath: operand fetch, product, saturating accumulate.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_a[b]    = bank_mem[b][addr_a_cur];
      rd_b[b]    = bank_mem[b][addr_b_cur];
      prod[b]    = PROD_W'(rd_a[b]) * PROD_W'(rd_b[b]);
      acc_in[b]  = (op_q == OP_MAC) ? ACC1_W'(prod[b]) : ACC1_W'(rd_a[b]);
      acc_sum[b] = ACC1_W'(acc_q[b]) + acc_in[b];
      acc_ovf[b] = acc_sum[b][ACC_WIDTH] != acc_sum[b][ACC_WIDTH-1];
      acc_sat[b] = acc_ovf[b] ? (acc_sum[b][ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                              : acc_sum[b][ACC_WIDTH-1:0];
      wr_sum[b]  = DAT1_W'(rd_a[b]) + DAT1_W'(wdata_q);
      wr_ovf[b]  = wr_sum[b][DATA_WIDTH] != wr_sum[b][DATA_WIDTH-1];
      wr_sat[b]  = wr_ovf[b] ? (wr_sum[b][DATA_WIDTH] ? DAT_MIN : DAT_MAX)
                             : wr_sum[b][DATA_WIDTH-1:0];
    end
  end

  // Cross-bank reduction; read_data ends up holding the lowest-index masked bank.
  always_comb begin
    total      = '0;
    read_data  = '0;
    active_cnt = 0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (mask_q[b]) begin
        total      = total + TOT_W'(acc_q[b]);
        read_data  = acc_q[b];
        active_cnt = active_cnt + 1;
      end
    end
    comb_ovf  = !((&total[TOT_W-1:ACC_WIDTH-1]) || !(|total[TOT_W-1:ACC_WIDTH-1]));
    comb_data = comb_ovf ? (total[TOT_W-1] ? ACC_MIN : ACC_MAX) : total[ACC_WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mask_d     = mask_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    len_d      = len_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    accum_d    = accum_q;
    sat_d      = sat_q;
    rsp_data_d = rsp_data_q;
    rsp_sat_d  = rsp_sat_q;
    rsp_err_d  = rsp_err_q;
    elem_d     = elem_q;
    energy_d   = energy_q;
    wr_en      = '0;
    is_vec     = 1'b0;
    elem_sum   = 0;
    energy_sum = 0;
    weight     = (op_q == OP_MAC) ? 5 : ((op_q == OP_SUM) ? 3 : 2);
    for (int b = 0; b < NUM_BANKS; b++) begin
      acc_d[b]   = acc_q[b];
      wr_data[b] = wdata_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d     = bus.cmd_op;
          mask_d   = bus.cmd_bank_mask;
          addr_a_d = bus.cmd_addr_a;
          addr_b_d = bus.cmd_addr_b;
          wdata_d  = bus.cmd_wdata;
          accum_d  = bus.cmd_accumulate;
          idx_d    = '0;
          sat_d    = 1'b0;
          for (int b = 0; b < NUM_BANKS; b++) acc_d[b] = '0;
          is_vec = (bus.cmd_op == OP_SUM) || (bus.cmd_op == OP_MAC);
          if (bus.cmd_op > 3'd3 || bus.cmd_bank_mask == '0 ||
              (is_vec && bus.cmd_len > LEN_W'(MAX_LEN))) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            rsp_sat_d  = 1'b0;
            state_d    = S_RESP;
          end else if (is_vec && bus.cmd_len == '0) begin
            len_d   = '0;
            state_d = S_COMBINE;
          end else begin
            len_d   = is_vec ? bus.cmd_len : LEN_W'(1);
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (mask_q[b]) begin
            case (op_q)
              OP_READ: acc_d[b] = ACC_WIDTH'(rd_a[b]);
              OP_WRITE: begin
                wr_en[b] = 1'b1;
                if (accum_q) begin
                  wr_data[b] = wr_sat[b];
                  sat_d      = sat_d | wr_ovf[b];
                end
              end
              default: begin
                acc_d[b] = acc_sat[b];
                sat_d    = sat_d | acc_ovf[b];
              end
            endcase
          end
        end
        elem_sum   = int'(elem_q) + active_cnt;
        energy_sum = int'(energy_q) + active_cnt * weight;
        elem_d     = (elem_sum > 65535) ? 16'hFFFF : 16'(elem_sum);
        energy_d   = (energy_sum > 65535) ? 16'hFFFF : 16'(energy_sum);
        idx_d      = idx_q + LEN_W'(1);
        if (idx_d == len_q) state_d = S_COMBINE;
      end

      S_COMBINE: begin
        rsp_err_d = 1'b0;
        rsp_sat_d = sat_q;
        case (op_q)
          OP_READ:  rsp_data_d = read_data;
          OP_WRITE: rsp_data_d = '0;
          default: begin
            rsp_data_d = comb_data;
            rsp_sat_d  = sat_q | comb_ovf;
          end
        endcase
        state_d = S_RESP;
      end

      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      mask_q     <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      accum_q    <= 1'b0;
      sat_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_sat_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      elem_q     <= '0;
      energy_q   <= '0;
      for (int b = 0; b < NUM_BANKS; b++) acc_q[b] <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      accum_q    <= accum_d;
      sat_q      <= sat_d;
      rsp_data_q <= rsp_data_d;
      rsp_sat_q  <= rsp_sat_d;
      rsp_err_q  <= rsp_err_d;
      elem_q     <= elem_d;
      energy_q   <= energy_d;
      for (int b = 0; b < NUM_BANKS; b++) acc_q[b] <= acc_d[b];
    end
  end

  // A write coinciding with reset is aborted; earlier writes stay in the array.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst_n && wr_en[b]) bank_mem[b][addr_a_cur] <= wr_data[b];
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_sat    = rsp_sat_q;
  assign bus.rsp_err    = rsp_err_q;
  assign stat_elem_ops  = elem_q;
  assign stat_energy    = energy_q;
endmodule

// File: tb/tb_dram_imc_mac_engine.sv
// Self-checking bench for dram_imc_mac_engine: directed scenarios plus randomized
// commands compared against a whole-command behavioural model of memory and stats.
module tb_dram_imc_mac_engine;
  logic        clk;
  logic        rst_n;
  logic [15:0] stat_elem_ops;
  logic [15:0] stat_energy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] data;
    logic        sat;
    logic        err;
    int          lat;
    int          elem;
    int          energy;
  } exp_t;

  exp_t        exp_q[$];
  int          model_mem [4][1024];
  int          model_elem;
  int          model_energy;
  logic [23:0] last_data;
  logic        last_sat;
  logic        last_err;
  int          last_lat;

  dram_imc_mac_engine_if #(.DATA_WIDTH(8), .ACC_WIDTH(24), .NUM_BANKS(4),
                           .BANK_AW(10), .LEN_W(7)) bus ();

  dram_imc_mac_engine #(.DATA_WIDTH(8), .ACC_WIDTH(24), .NUM_BANKS(4),
                        .BANK_DEPTH(1024), .MAX_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .stat_elem_ops(stat_elem_ops), .stat_energy(stat_energy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic finishRun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic longint clampv(longint v, longint lo, longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Whole-command reference: walks each masked bank's elements in order.
  function automatic exp_t predict(int op, int mask, int a, int b, int len, int wdata, bit accum);
    exp_t   e;
    longint acc [4];
    longint v, c, total;
    int     n, active, w, pa, pb;
    bit     sat;
    e.data = '0; e.sat = 1'b0; e.err = 1'b0; e.lat = 1;
    if (op > 3 || mask == 0 || (op >= 2 && len > 64)) begin
      e.err = 1'b1;
    end else begin
      n = (op < 2) ? 1 : len;
      w = (op == 3) ? 5 : ((op == 2) ? 3 : 2);
      active = 0; sat = 1'b0; total = 0;
      for (int k = 0; k < 4; k++) begin
        acc[k] = 0;
        if (((mask >> k) & 1) == 1) begin
          active++;
          for (int i = 0; i < n; i++) begin
            pa = (a + i) % 1024;
            pb = (b + i) % 1024;
            if (op == 0) acc[k] = model_mem[k][pa];
            else if (op == 1) begin
              v = accum ? longint'(model_mem[k][pa]) + wdata : longint'(wdata);
              c = clampv(v, -128, 127);
              if (c != v) sat = 1'b1;
              model_mem[k][pa] = int'(c);
            end else begin
              v = acc[k] + ((op == 3) ? longint'(model_mem[k][pa]) * model_mem[k][pb]
                                      : longint'(model_mem[k][pa]));
              c = clampv(v, -(longint'(1) << 23), (longint'(1) << 23) - 1);
              if (c != v) sat = 1'b1;
              acc[k] = c;
            end
          end
          total += acc[k];
        end
      end
      if (op == 0) begin
        for (int k = 3; k >= 0; k--) if (((mask >> k) & 1) == 1) v = acc[k];
      end else if (op == 1) v = 0;
      else begin
        v = clampv(total, -(longint'(1) << 23), (longint'(1) << 23) - 1);
        if (v != total) sat = 1'b1;
      end
      e.data = 24'(v);
      e.sat  = sat;
      e.lat  = n + 2;
      model_elem   = int'(clampv(longint'(model_elem) + active * n, 0, 65535));
      model_energy = int'(clampv(longint'(model_energy) + active * n * w, 0, 65535));
    end
    e.elem   = model_elem;
    e.energy = model_energy;
    return e;
  endfunction

  // Issues one command from an idle engine, waits for its response, then
  // holds rsp_ready low for `stall` cycles before completing the handshake.
  task automatic applyStimulus(input int op, input int mask, input int a, input int b,
                               input int len, input int wdata, input bit accum, input int stall);
    exp_t e;
    int   cyc;
    e = predict(op, mask, a, b, len, wdata, accum);
    exp_q.push_back(e);
    bus.cmd_op         = 3'(op);
    bus.cmd_bank_mask  = 4'(mask);
    bus.cmd_addr_a     = 10'(a);
    bus.cmd_addr_b     = 10'(b);
    bus.cmd_len        = 7'(len);
    bus.cmd_wdata      = 8'(wdata);
    bus.cmd_accumulate = accum;
    bus.cmd_valid      = 1'b1;
    checkOutput("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.rsp_valid) begin
      checks++; failures++;
      $display("[TB] FAIL rsp_timeout actual=no rsp_valid expected=rsp_valid within 200 cycles");
      finishRun();
    end
    checkOutput("latency", cyc, e.lat);
    last_data = bus.rsp_data;
    last_sat  = bus.rsp_sat;
    last_err  = bus.rsp_err;
    last_lat  = cyc;
    repeat (stall) begin @(posedge clk); #1; end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_elem   = 0;
    model_energy = 0;
  endtask

  // Response checker: every valid cycle (including stalls) against the model.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_rsp actual=rsp_valid=1 expected=rsp_valid=0 at %0t", $time);
      end else begin
        checkOutput("rsp_data", bus.rsp_data, exp_q[0].data);
        checkOutput("rsp_sat", bus.rsp_sat, exp_q[0].sat);
        checkOutput("rsp_err", bus.rsp_err, exp_q[0].err);
        checkOutput("cmd_ready_busy", bus.cmd_ready, 0);
        if (bus.rsp_ready) begin
          checkOutput("stat_elem_ops", stat_elem_ops, exp_q[0].elem);
          checkOutput("stat_energy", stat_energy, exp_q[0].energy);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    checks++; failures++;
    $display("[TB] FAIL watchdog actual=still running expected=finished");
    finishRun();
  end

  initial begin
    int op, mask, len, n, a, b, r;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_bank_mask = '0; bus.cmd_addr_a = '0;
    bus.cmd_addr_b = '0; bus.cmd_len = '0; bus.cmd_wdata = '0; bus.cmd_accumulate = 1'b0;
    bus.rsp_ready = 1'b0;
    model_elem = 0; model_energy = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_data", bus.rsp_data, 0);
    checkOutput("reset_rsp_sat", bus.rsp_sat, 0);
    checkOutput("reset_rsp_err", bus.rsp_err, 0);
    checkOutput("reset_stat_elem", stat_elem_ops, 0);
    checkOutput("reset_stat_energy", stat_energy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] preload window 1008..1023, 0..79 in every bank");
    for (int k = 0; k < 4; k++)
      for (int off = 0; off < 96; off++)
        applyStimulus(1, 1 << k, (1008 + off) % 1024, 0, 0, int'($urandom_range(0, 255)) - 128, 1'b0, 0);

    $display("[TB] write then read");
    applyStimulus(1, 1, 5, 0, 0, 'h7E, 1'b0, 0);
    applyStimulus(0, 1, 5, 0, 0, 0, 1'b0, 0);
    checkOutput("lit_read_7e", last_data, 24'h00007E);
    checkOutput("lit_read_lat", last_lat, 3);
    applyStimulus(1, 1, 6, 0, 0, -128, 1'b0, 0);
    applyStimulus(0, 1, 6, 0, 0, 0, 1'b0, 0);
    checkOutput("lit_read_80", last_data, 24'hFFFF80);

    $display("[TB] accumulate saturation");
    applyStimulus(1, 1, 10, 0, 0, 100, 1'b0, 0);
    applyStimulus(1, 1, 10, 0, 0, 50, 1'b1, 0);
    checkOutput("lit_acc_pos_sat", last_sat, 1);
    applyStimulus(0, 1, 10, 0, 0, 0, 1'b0, 0);
    checkOutput("lit_acc_pos_val", last_data, 24'h00007F);
    applyStimulus(1, 1, 10, 0, 0, -100, 1'b0, 0);
    applyStimulus(1, 1, 10, 0, 0, -50, 1'b1, 0);
    checkOutput("lit_acc_neg_sat", last_sat, 1);
    applyStimulus(0, 1, 10, 0, 0, 0, 1'b0, 0);
    checkOutput("lit_acc_neg_val", last_data, 24'hFFFF80);

    $display("[TB] wrap-around SUM with back-pressure");
    applyStimulus(1, 4, 1022, 0, 0, 1, 1'b0, 0);
    applyStimulus(1, 4, 1023, 0, 0, 2, 1'b0, 0);
    applyStimulus(1, 4, 0, 0, 0, 3, 1'b0, 0);
    applyStimulus(1, 4, 1, 0, 0, 4, 1'b0, 0);
    applyStimulus(2, 4, 1022, 0, 4, 0, 1'b0, 5);
    checkOutput("lit_wrap_sum", last_data, 24'd10);

    $display("[TB] error commands");
    applyStimulus(7, 1, 0, 0, 1, 0, 1'b0, 0);
    checkOutput("lit_err_op", last_err, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1'b0, 1);
    checkOutput("lit_err_mask", last_err, 1);
    applyStimulus(2, 1, 0, 0, 65, 0, 1'b0, 0);
    checkOutput("lit_err_len", last_err, 1);
    checkOutput("lit_err_len_lat", last_lat, 1);

    $display("[TB] multi-bank MAC");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 15, i, 0, 0, i + 1, 1'b0, 0);
      applyStimulus(1, 15, 64 + i, 0, 0, 2, 1'b0, 0);
    end
    doReset();
    applyStimulus(3, 15, 0, 64, 8, 0, 1'b0, 0);
    checkOutput("lit_mac_data", last_data, 24'd288);
    checkOutput("lit_mac_lat", last_lat, 10);
    checkOutput("lit_mac_elem", stat_elem_ops, 32);
    checkOutput("lit_mac_energy", stat_energy, 160);

    $display("[TB] reset during MAC run");
    bus.cmd_op = 3'd3; bus.cmd_bank_mask = 4'hF; bus.cmd_addr_a = 10'd0;
    bus.cmd_addr_b = 10'd64; bus.cmd_len = 7'd16; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    doReset();
    checkOutput("midrst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("midrst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("midrst_stat_elem", stat_elem_ops, 0);
    checkOutput("midrst_stat_energy", stat_energy, 0);
    applyStimulus(0, 2, 3, 0, 0, 0, 1'b0, 0);
    checkOutput("lit_post_rst_read", last_data, 24'd4);

    $display("[TB] randomized commands");
    for (int t = 0; t < 120; t++) begin
      r    = int'($urandom_range(0, 19));
      op   = int'($urandom_range(0, 3));
      mask = int'($urandom_range(1, 15));
      len  = int'($urandom_range(0, 64));
      if (r == 0) op = int'($urandom_range(4, 7));
      else if (r == 1) mask = 0;
      else if (r == 2) begin
        op  = int'($urandom_range(2, 3));
        len = int'($urandom_range(65, 127));
      end
      n = (op < 2 || len > 64) ? 1 : len;
      a = (1008 + int'($urandom_range(0, 96 - n))) % 1024;
      b = (1008 + int'($urandom_range(0, 96 - n))) % 1024;
      applyStimulus(op, mask, a, b, len, int'($urandom_range(0, 255)) - 128,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("[TB] long MAC burst into energy saturation");
    for (int t = 0; t < 55; t++)
      applyStimulus(3, 15, (1008 + int'($urandom_range(0, 32))) % 1024,
                    (1008 + int'($urandom_range(0, 32))) % 1024, 64, 0, 1'b0, 0);
    checkOutput("lit_energy_sat", stat_energy, 16'hFFFF);

    finishRun();
  end
endmodule
